// File: rtl/run_check_pkg.sv
// rtl/run_check_pkg.sv - shared state type and default constants for the run/check controller
package run_check_pkg;

    localparam int DEF_XLEN         = 32;
    localparam int DEF_NUM_CHECKS   = 8;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_MAX_CYCLES   = 100;
    localparam int DEF_HALT_REPEAT  = 4;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_RST,
        RUN,
        CHECK_ADDR,
        CHECK_CMP,
        DONE
    } run_state_t;

endpackage

// File: rtl/halt_detector.sv
// rtl/halt_detector.sv - flags a CPU halt once the monitored PC stays unchanged long enough
module halt_detector #(
    parameter int XLEN        = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [XLEN-1:0] pc,
    output logic            halted
);

    localparam int CW = $clog2(HALT_REPEAT + 1);

    logic [XLEN-1:0] prev_pc;
    logic            valid;
    logic [CW-1:0]   rep_cnt;
    logic [CW-1:0]   rep_next;

    // The first cycle after clear has no previous PC, so it only captures.
    always_comb begin
        rep_next = '0;
        if (valid && (pc == prev_pc)) begin
            rep_next = (rep_cnt == CW'(HALT_REPEAT - 1)) ? rep_cnt : rep_cnt + 1'b1;
        end
    end

    assign halted = !clear && valid && (rep_next == CW'(HALT_REPEAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            prev_pc <= '0;
            rep_cnt <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
            rep_cnt <= '0;
        end else begin
            valid   <= 1'b1;
            prev_pc <= pc;
            rep_cnt <= rep_next;
        end
    end

endmodule

// File: rtl/run_check_ctrl.sv
// rtl/run_check_ctrl.sv - resets and runs a CPU until halt or timeout, then checks registers
module run_check_ctrl
    import run_check_pkg::*;
#(
    parameter int XLEN         = DEF_XLEN,
    parameter int NUM_CHECKS   = DEF_NUM_CHECKS,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int HALT_REPEAT  = DEF_HALT_REPEAT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]     cfg_idx,
    input  logic                              cfg_en,
    input  logic [4:0]                        cfg_reg,
    input  logic [XLEN-1:0]                   cfg_val,
    input  logic [XLEN-1:0]                   pc_mon,
    output logic                              cpu_resetn,
    output logic [4:0]                        dbg_addr,
    input  logic [XLEN-1:0]                   dbg_data,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]     first_fail_idx,
    output logic [XLEN-1:0]                   cycles_run
);

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    run_state_t state, state_next;

    logic [IW-1:0]         idx;
    logic [RW-1:0]         hold_cnt;
    logic [NUM_CHECKS-1:0] chk_en;
    logic [4:0]            chk_reg [NUM_CHECKS];
    logic [XLEN-1:0]       chk_val [NUM_CHECKS];

    logic            idle_like;
    logic            cfg_write;
    logic            launch;
    logic            halted;
    logic [XLEN-1:0] cycles_inc;
    logic            budget_hit;
    logic            last_idx;
    logic            mismatch;

    assign idle_like  = (state == IDLE) || (state == DONE);
    // A table write takes the cycle; a coincident start is dropped.
    assign cfg_write  = idle_like && cfg_we;
    assign launch     = idle_like && start && !cfg_we;
    assign cycles_inc = (cycles_run == XLEN'(MAX_CYCLES)) ? cycles_run : cycles_run + 1'b1;
    assign budget_hit = (cycles_inc == XLEN'(MAX_CYCLES));
    assign last_idx   = (idx == IW'(NUM_CHECKS - 1));
    assign mismatch   = (dbg_data != chk_val[idx]);

    halt_detector #(
        .XLEN        (XLEN),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detector (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != RUN),
        .pc     (pc_mon),
        .halted (halted)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (launch) state_next = HOLD_RST;
            HOLD_RST:   if (hold_cnt == RW'(RESET_CYCLES - 1)) state_next = RUN;
            RUN:        if (halted || budget_hit) state_next = CHECK_ADDR;
            CHECK_ADDR: begin
                if (chk_en[idx])   state_next = CHECK_CMP;
                else if (last_idx) state_next = DONE;
            end
            CHECK_CMP:  state_next = last_idx ? DONE : CHECK_ADDR;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            hold_cnt       <= '0;
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            cycles_run     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (launch) begin
                        idx            <= '0;
                        hold_cnt       <= '0;
                        timeout        <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        cycles_run     <= '0;
                    end
                end
                HOLD_RST: hold_cnt <= hold_cnt + 1'b1;
                RUN: begin
                    cycles_run <= cycles_inc;
                    if (!halted && budget_hit) timeout <= 1'b1;
                end
                CHECK_ADDR: begin
                    if (!chk_en[idx] && !last_idx) idx <= idx + 1'b1;
                end
                CHECK_CMP: begin
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) first_fail_idx <= idx;
                    end
                    if (!last_idx) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          chk_en          <= '0;
        else if (cfg_write) chk_en[cfg_idx] <= cfg_en;
    end

    always_ff @(posedge clk) begin
        if (cfg_write) begin
            chk_reg[cfg_idx] <= cfg_reg;
            chk_val[cfg_idx] <= cfg_val;
        end
    end

    // The CPU stays out of reset through checking and DONE so its registers survive.
    assign cpu_resetn = (state == RUN) || (state == CHECK_ADDR) ||
                        (state == CHECK_CMP) || (state == DONE);
    assign done       = (state == DONE);
    assign pass       = done && (fail_count == '0) && !timeout;
    assign dbg_addr   = (state == CHECK_ADDR) ? chk_reg[idx] : 5'd0;

endmodule

// File: doc/run_check_ctrl.md
RUN_CHECK_CTRL -- requirements
Module: run_check_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, the datapath/PC/register width.
REQ-002 SHALL have parameter NUM_CHECKS, default 8, the number of expected-register entries (1..32).
REQ-003 SHALL have parameter RESET_CYCLES, default 2, the CPU reset hold length in cycles (>=1).
REQ-004 SHALL have parameter MAX_CYCLES, default 100, the run-cycle budget before timeout.
REQ-005 SHALL have parameter HALT_REPEAT, default 4, the consecutive cycles of an unchanged PC that declare a halt.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, a one-cycle pulse that launches a run; honoured only in IDLE or DONE.
REQ-009 SHALL have port cfg_we, input, 1, the check-table write strobe; honoured only in IDLE or DONE.
REQ-010 SHALL have port cfg_idx, input, $clog2(NUM_CHECKS), the check-table entry index.
REQ-011 SHALL have ports cfg_en (1), cfg_reg (5) and cfg_val (XLEN), inputs, carrying the entry enable, register number and expected value.
REQ-012 SHALL have port pc_mon, input, XLEN, the PC of the CPU's ID/EX stage.
REQ-013 SHALL have port cpu_resetn, output, 1, the active-low reset driven to the CPU.
REQ-014 SHALL have port dbg_addr, output, 5, the register-file debug read address; dbg_data (input, XLEN) returns one cycle later.
REQ-015 SHALL have ports done (1), pass (1), timeout (1), fail_count ($clog2(NUM_CHECKS+1)), first_fail_idx ($clog2(NUM_CHECKS)) and cycles_run (XLEN), all outputs.

Function
REQ-016 SHALL implement the FSM states IDLE, HOLD_RST, RUN, CHECK_ADDR, CHECK_CMP and DONE.
REQ-017 SHALL move IDLE/DONE -> HOLD_RST on start, clearing done, pass, timeout, fail_count, first_fail_idx and cycles_run.
REQ-018 SHALL drive cpu_resetn=0 in HOLD_RST for exactly RESET_CYCLES cycles, then enter RUN with cpu_resetn=1.
REQ-019 SHALL increment cycles_run once per RUN cycle, saturating at MAX_CYCLES.
REQ-020 SHALL count repeats while pc_mon equals its previous-cycle value and clear the count on any change; the first RUN cycle only captures pc_mon.
REQ-021 SHALL leave RUN for CHECK_ADDR when the repeat count reaches HALT_REPEAT-1 (halt) or cycles_run reaches MAX_CYCLES (timeout=1); halt has priority when both occur in the same cycle.
REQ-022 SHALL keep cpu_resetn=1 during checking so that register state is preserved.
REQ-023 SHALL scan entries 0..NUM_CHECKS-1 in order: CHECK_ADDR drives dbg_addr=cfg_reg[i], and CHECK_CMP compares dbg_data against cfg_val[i].
REQ-024 SHALL skip disabled entries in one cycle, without a read and without being counted.
REQ-025 SHALL, on a mismatch, increment fail_count and, on the first mismatch only, record first_fail_idx=i.
REQ-026 SHALL pass register x0 entries through the same compare, with x0 expected to read 0.
REQ-027 SHALL enter DONE after the last entry, set done=1 and set pass=(fail_count==0)&&!timeout.
REQ-028 SHALL hold the outputs in DONE until the next start.
REQ-029 SHALL ignore start outside IDLE/DONE.
REQ-030 SHALL ignore cfg_we outside IDLE/DONE.
REQ-031 SHALL let cfg_we win if cfg_we and start coincide in the same cycle: the table write completes first and the run starts on the next start pulse.

Reset
REQ-032 SHALL, on asynchronous reset, immediately enter IDLE with cpu_resetn=0, done=0, pass=0, timeout=0, fail_count=0, first_fail_idx=0, cycles_run=0, dbg_addr=0 and all check-table enables cleared.
REQ-033 SHALL return to IDLE on a reset mid-run, discarding partial results.

Structure
REQ-034 SHALL place the state enum run_state_t and the default parameter constants in the shared package run_check_pkg.
REQ-035 SHALL implement the PC-repeat counter and comparator as the sub-module halt_detector (params XLEN, HALT_REPEAT; ports clk, reset, clear, pc, halted).
REQ-036 SHALL store the check table in flops.

Verification
REQ-037 SHALL cover: program ending in a self-jump (PC 0x14 repeating), entries {x1=0x8, x10=0x1, x11=0x14} -> done=1, pass=1, fail_count=0, timeout=0.
REQ-038 SHALL cover: same program with x11 expected 0x18 -> pass=0, fail_count=1, first_fail_idx=2.
REQ-039 SHALL cover: PC never repeating with MAX_CYCLES=100 -> timeout=1, cycles_run=100, pass=0 even when all compares match.
REQ-040 SHALL cover: start pulse -> cpu_resetn low for exactly RESET_CYCLES cycles after start, then high.
REQ-041 SHALL cover: reset asserted during RUN -> IDLE within the same cycle, all outputs 0, cpu_resetn=0.
REQ-042 SHALL cover: cfg_we during RUN changing entry 0 -> ignored; start during CHECK_CMP -> ignored, with results unchanged.
